// File: rtl/iob_fifo_pkg.sv
// Shared helpers for the iob FIFO family: width-ratio derivation and
// integer max/min used when sizing asymmetric FIFOs.
package iob_fifo_pkg;

   // Number of narrow words packed into one wide word
   function automatic int ratio_f(input int w_w, input int r_w);
      return r_w / w_w;
   endfunction

   // Address bits consumed by the narrow-word position inside a wide word
   function automatic int log2ratio_f(input int w_w, input int r_w);
      return $clog2(r_w / w_w);
   endfunction

   function automatic int max_f(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   function automatic int min_f(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/iob_fifo_asym_ptr.sv
// Pointer and occupancy bookkeeping for the asymmetric FIFO.
// wptr counts narrow words, rptr counts wide words; level is in narrow words.
module iob_fifo_asym_ptr #(
   parameter int ADDR_W    = 4,
   parameter int LOG2RATIO = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        w_en,
   input  logic                        r_en,
   output logic                        w_accept,
   output logic                        r_accept,
   output logic                        w_full,
   output logic                        r_empty,
   output logic [ADDR_W-1:0]           wptr,
   output logic [ADDR_W-LOG2RATIO-1:0] rptr,
   output logic [ADDR_W:0]             level
);

   localparam logic [ADDR_W:0] RATIO_L = (ADDR_W+1)'(2**LOG2RATIO);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(2**ADDR_W);

   logic [ADDR_W:0] level_nxt;

   // Flags come straight from the level so they react in the same cycle
   assign w_full   = (level == DEPTH_L);
   assign r_empty  = (level < RATIO_L);
   assign w_accept = w_en && !w_full;
   assign r_accept = r_en && !r_empty;

   // Net occupancy change: +1 per write, -RATIO per read (a read needs
   // level >= RATIO, so the subtraction never wraps)
   always_comb begin
      level_nxt = level + (ADDR_W+1)'(w_accept);
      if (r_accept) level_nxt = level_nxt - RATIO_L;
   end

   // Pointers wrap naturally at their own widths
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (w_accept) wptr <= wptr + 1'b1;
         if (r_accept) rptr <= rptr + 1'b1;
         level <= level_nxt;
      end
   end

endmodule

// File: rtl/iob_fifo_sync_asym_ctrl.sv
// Synchronous FIFO controller with narrow writes and wide reads, driving an
// external narrow-write/wide-read RAM with a registered (1-cycle) read port.
// Optional feature macro IOB_FIFO_ERR_FLAGS_EN adds sticky w_overflow and
// r_underflow flags.
module iob_fifo_sync_asym_ctrl
   import iob_fifo_pkg::*;
#(
   parameter int W_DATA_W  = 8,
   parameter int R_DATA_W  = 32,
   parameter int ADDR_W    = 4,
   localparam int RATIO     = ratio_f(W_DATA_W, R_DATA_W),
   localparam int LOG2RATIO = log2ratio_f(W_DATA_W, R_DATA_W)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        w_en,
   input  logic [W_DATA_W-1:0]         w_data,
   output logic                        w_full,
   input  logic                        r_en,
   output logic [R_DATA_W-1:0]         r_data,
   output logic                        r_valid,
   output logic                        r_empty,
   output logic [ADDR_W:0]             level,
`ifdef IOB_FIFO_ERR_FLAGS_EN
   output logic                        w_overflow,
   output logic                        r_underflow,
`endif
   output logic                        ext_mem_w_en,
   output logic [ADDR_W-1:0]           ext_mem_w_addr,
   output logic [W_DATA_W-1:0]         ext_mem_w_data,
   output logic                        ext_mem_r_en,
   output logic [ADDR_W-LOG2RATIO-1:0] ext_mem_r_addr,
   input  logic [R_DATA_W-1:0]         ext_mem_r_data
);

   logic                        w_accept;
   logic                        r_accept;
   logic [ADDR_W-1:0]           wptr;
   logic [ADDR_W-LOG2RATIO-1:0] rptr;

   iob_fifo_asym_ptr #(
      .ADDR_W    (ADDR_W),
      .LOG2RATIO (LOG2RATIO)
   ) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .w_en     (w_en),
      .r_en     (r_en),
      .w_accept (w_accept),
      .r_accept (r_accept),
      .w_full   (w_full),
      .r_empty  (r_empty),
      .wptr     (wptr),
      .rptr     (rptr),
      .level    (level)
   );

   // RAM port is a direct, combinational view of the accepted requests
   assign ext_mem_w_en   = w_accept;
   assign ext_mem_w_addr = wptr;
   assign ext_mem_w_data = w_data;
   assign ext_mem_r_en   = r_accept;
   assign ext_mem_r_addr = rptr;
   // The RAM packs little-endian by address, so its wide word is already
   // in oldest-in-LSBs order
   assign r_data         = ext_mem_r_data;

   // r_valid tracks the RAM read latency; reset drops any read in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_valid <= 1'b0;
      else     r_valid <= r_accept;
   end

`ifdef IOB_FIFO_ERR_FLAGS_EN
   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_en && w_full)  w_overflow  <= 1'b1;
         if (r_en && r_empty) r_underflow <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
// Directed self-checking bench for iob_fifo_sync_asym_ctrl (8->32, depth 16)
// with a behavioural narrow-write/wide-read RAM attached to the ext_mem port.
module tb_iob_fifo_sync_asym_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        w_en;
   logic [7:0]  w_data;
   logic        w_full;
   logic        r_en;
   logic [31:0] r_data;
   logic        r_valid;
   logic        r_empty;
   logic [4:0]  level;
`ifdef IOB_FIFO_ERR_FLAGS_EN
   logic        w_overflow;
   logic        r_underflow;
`endif
   logic        ext_mem_w_en;
   logic [3:0]  ext_mem_w_addr;
   logic [7:0]  ext_mem_w_data;
   logic        ext_mem_r_en;
   logic [1:0]  ext_mem_r_addr;
   logic [31:0] ext_mem_r_data;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   iob_fifo_sync_asym_ctrl #(
      .W_DATA_W (8),
      .R_DATA_W (32),
      .ADDR_W   (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .w_en           (w_en),
      .w_data         (w_data),
      .w_full         (w_full),
      .r_en           (r_en),
      .r_data         (r_data),
      .r_valid        (r_valid),
      .r_empty        (r_empty),
      .level          (level),
`ifdef IOB_FIFO_ERR_FLAGS_EN
      .w_overflow     (w_overflow),
      .r_underflow    (r_underflow),
`endif
      .ext_mem_w_en   (ext_mem_w_en),
      .ext_mem_w_addr (ext_mem_w_addr),
      .ext_mem_w_data (ext_mem_w_data),
      .ext_mem_r_en   (ext_mem_r_en),
      .ext_mem_r_addr (ext_mem_r_addr),
      .ext_mem_r_data (ext_mem_r_data)
   );

   // External RAM: byte writes, 32-bit registered reads, little-endian
   logic [7:0] mem [16];
   always @(posedge clk) begin
      if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
      if (ext_mem_r_en)
         ext_mem_r_data <= {mem[{ext_mem_r_addr, 2'd3}], mem[{ext_mem_r_addr, 2'd2}],
                            mem[{ext_mem_r_addr, 2'd1}], mem[{ext_mem_r_addr, 2'd0}]};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock of stimulus: inputs applied at negedge, released after posedge
   task automatic step(input logic we, input logic [7:0] wd, input logic re);
      @(negedge clk);
      w_en = we; w_data = wd; r_en = re;
      @(posedge clk);
      #1;
      w_en = 1'b0; r_en = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_word;
      rst = 1'b1; w_en = 1'b0; w_data = '0; r_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_full", 32'(w_full), 32'd0);
      chk("rst_empty", 32'(r_empty), 32'd1);
      chk("rst_rvalid", 32'(r_valid), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Basic 4-byte pack and read
      step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
      chk("b_level4", 32'(level), 32'd4);
      chk("b_empty0", 32'(r_empty), 32'd0);
      step(0, 8'h00, 1);
      chk("b_rvalid", 32'(r_valid), 32'd1);
      chk("b_rdata", r_data, 32'h44332211);
      chk("b_level0", 32'(level), 32'd0);
      chk("b_empty1", 32'(r_empty), 32'd1);
      step(0, 8'h00, 0);
      chk("b_rvalid_1cyc", 32'(r_valid), 32'd0);

      // Read rejected at level 3
      step(1, 8'ha1, 0); step(1, 8'ha2, 0); step(1, 8'ha3, 0);
      chk("u_level3", 32'(level), 32'd3);
      @(negedge clk); r_en = 1'b1; #1;
      chk("u_memren", 32'(ext_mem_r_en), 32'd0);
      @(posedge clk); #1; r_en = 1'b0;
      chk("u_rvalid", 32'(r_valid), 32'd0);
      chk("u_level_hold", 32'(level), 32'd3);
`ifdef IOB_FIFO_ERR_FLAGS_EN
      chk("u_underflow", 32'(r_underflow), 32'd1);
`endif
      step(1, 8'ha4, 0);
      step(0, 8'h00, 1);
      chk("u_rdata", r_data, 32'ha4a3a2a1);

      // Fill to full (wptr wraps from 8), then overflow attempt
      for (int i = 0; i < 16; i++) step(1, 8'hb0 + 8'(i), 0);
      chk("f_level16", 32'(level), 32'd16);
      chk("f_full", 32'(w_full), 32'd1);
      chk("f_waddr", 32'(ext_mem_w_addr), 32'd8);
      step(1, 8'hff, 0);
      chk("f_level_hold", 32'(level), 32'd16);
      chk("f_waddr_hold", 32'(ext_mem_w_addr), 32'd8);
`ifdef IOB_FIFO_ERR_FLAGS_EN
      chk("f_overflow", 32'(w_overflow), 32'd1);
`endif

      // Simultaneous write+read at full: only the read goes
      step(1, 8'hee, 1);
      chk("s16_rdata", r_data, 32'hb3b2b1b0);
      chk("s16_level", 32'(level), 32'd12);
      step(0, 8'h00, 1);
      chk("s12_rdata", r_data, 32'hb7b6b5b4);
      chk("s12_level", 32'(level), 32'd8);
      // At level 8 both are accepted
      step(1, 8'hc0, 1);
      chk("s8_rdata", r_data, 32'hbbbab9b8);
      chk("s8_level", 32'(level), 32'd5);
      step(0, 8'h00, 1);
      chk("s5_rdata", r_data, 32'hbfbebdbc);
      chk("s5_level", 32'(level), 32'd1);
      step(1, 8'hc1, 0); step(1, 8'hc2, 0); step(1, 8'hc3, 0);
      step(0, 8'h00, 1);
      chk("s_wrap_rdata", r_data, 32'hc3c2c1c0);
      chk("s_wrap_level", 32'(level), 32'd0);

      // 40 writes of 0x01..0x28 interleaved with 10 reads, pointers wrap
      for (int i = 0; i < 40; i++) begin
         step(1, 8'(i + 1), 0);
         if (i % 4 == 3) begin
            step(0, 8'h00, 1);
            exp_word = {8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)};
            chk("i_rvalid", 32'(r_valid), 32'd1);
            chk("i_rdata", r_data, exp_word);
            chk("i_level", 32'(level), 32'd0);
         end
      end

      // Reset while a read is in flight
      step(1, 8'hd1, 0); step(1, 8'hd2, 0); step(1, 8'hd3, 0); step(1, 8'hd4, 0);
      @(negedge clk); r_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; r_en = 1'b0;
      #1;
      chk("r_rvalid_async", 32'(r_valid), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      chk("r_rvalid_after", 32'(r_valid), 32'd0);
      chk("r_level", 32'(level), 32'd0);
      chk("r_empty", 32'(r_empty), 32'd1);
      chk("r_waddr", 32'(ext_mem_w_addr), 32'd0);
      chk("r_raddr", 32'(ext_mem_r_addr), 32'd0);
`ifdef IOB_FIFO_ERR_FLAGS_EN
      chk("r_overflow_clr", 32'(w_overflow), 32'd0);
      chk("r_underflow_clr", 32'(r_underflow), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iob_fifo_sync_asym_ctrl.md
IOB_FIFO_SYNC_ASYM_CTRL -- requirements
Module: iob_fifo_sync_asym_ctrl

Interface
REQ-001 SHALL have parameter W_DATA_W, default 8: write word width in bits.
REQ-002 SHALL have parameter R_DATA_W, default 32: read word width in bits, an integer power-of-2 multiple of W_DATA_W.
REQ-003 SHALL have parameter ADDR_W, default 4: write-side address width; depth is 2**ADDR_W narrow words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port w_en, input, 1 bit: write request.
REQ-007 SHALL have port w_data, input, W_DATA_W bits: write data.
REQ-008 SHALL have port w_full, output, 1 bit: the FIFO cannot accept a write.
REQ-009 SHALL have port r_en, input, 1 bit: read request.
REQ-010 SHALL have port r_data, output, R_DATA_W bits: read data, driven directly from ext_mem_r_data.
REQ-011 SHALL have port r_valid, output, 1 bit: r_data holds an accepted read this cycle.
REQ-012 SHALL have port r_empty, output, 1 bit: fewer than RATIO narrow words are stored.
REQ-013 SHALL have port level, output, ADDR_W+1 bits: occupancy in narrow words.
REQ-014 SHALL have ports ext_mem_w_en (1), ext_mem_w_addr (ADDR_W), ext_mem_w_data (W_DATA_W), ext_mem_r_en (1) and ext_mem_r_addr (ADDR_W-LOG2RATIO) as outputs, and ext_mem_r_data (R_DATA_W) as an input: the external narrow-write/wide-read RAM port with registered read, latency 1.

Function
REQ-015 SHALL define RATIO = R_DATA_W/W_DATA_W and LOG2RATIO = clog2(RATIO).
REQ-016 SHALL accept a write iff w_en && !w_full; ext_mem_w_en = accepted write, ext_mem_w_addr = wptr, ext_mem_w_data = w_data, all combinational.
REQ-017 SHALL accept a read iff r_en && !r_empty; ext_mem_r_en = accepted read, ext_mem_r_addr = rptr, both combinational.
REQ-018 SHALL increment wptr (ADDR_W bits) by 1 per accepted write and rptr (ADDR_W-LOG2RATIO bits) by 1 per accepted read; both wrap modulo 2**width with no extra logic.
REQ-019 SHALL update level by +1 per accepted write and -RATIO per accepted read; when both occur in the same cycle, the net change is 1-RATIO.
REQ-020 SHALL assert w_full combinationally iff level == 2**ADDR_W, and r_empty iff level < RATIO.
REQ-021 SHALL assert r_valid one cycle after an accepted read, for exactly one cycle per read.
REQ-022 SHALL pack data little-endian: the oldest narrow word occupies r_data[W_DATA_W-1:0].
REQ-023 SHALL ignore writes while full and reads while empty, leaving pointers and level unchanged.

Reset
REQ-024 SHALL asynchronously reset on rst=1: wptr=0, rptr=0, level=0, r_valid=0, hence w_full=0 and r_empty=1; the state of the memory contents is irrelevant.
REQ-025 SHALL discard any read in flight when rst asserts: r_valid is 0 on the cycle after reset is released.

Configuration
REQ-026 SHALL, with IOB_FIFO_ERR_FLAGS_EN defined, add sticky outputs w_overflow and r_underflow, reset to 0 and set on a rejected write or rejected read respectively, cleared only by rst.
REQ-027 SHALL, without IOB_FIFO_ERR_FLAGS_EN, omit those ports and their logic entirely.

Structure
REQ-028 SHALL place the RATIO/LOG2RATIO derivation functions and the max/min helpers in shared package iob_fifo_pkg.
REQ-029 SHALL implement pointer/level bookkeeping in one sub-module, iob_fifo_asym_ptr, instantiated once.

Verification (W_DATA_W=8, R_DATA_W=32, ADDR_W=4)
REQ-030 SHALL check that writing 0x11, 0x22, 0x33, 0x44 then reading gives r_valid=1 one cycle later with r_data=0x44332211, level=0, r_empty=1.
REQ-031 SHALL check that 16 writes give w_full=1 and level=16; the 17th write keeps level=16 and sets w_overflow=1 when IOB_FIFO_ERR_FLAGS_EN is defined.
REQ-032 SHALL check that a read with level=3 is rejected: ext_mem_r_en=0, no r_valid, and r_underflow=1 when IOB_FIFO_ERR_FLAGS_EN is defined.
REQ-033 SHALL check that a simultaneous write and read at level=16 accepts only the read (level becomes 12), and at level=8 accepts both (level becomes 5).
REQ-034 SHALL check that 40 writes interleaved with 10 reads, with wptr and rptr wrapping, return data in order with no loss.
REQ-035 SHALL check that asserting rst mid-read leaves r_valid=0 after release, with level=0 and wptr=rptr=0.
